// File: rtl/fpadd.sv
// Multi-cycle IEEE-754 adder/subtractor: IDLE->UNPACK->ALIGN->ADD->NORM->ROUND, one stage per clock.
// Denormals flush to zero, rounding is nearest-even, and the result is registered with a level done flag.
module fpadd #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      sub,
  input  logic [EXP_W+FRAC_W:0]     dataa,
  input  logic [EXP_W+FRAC_W:0]     datab,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic                      done
);

  localparam int unsigned W     = 1 + EXP_W + FRAC_W;
  localparam int unsigned MAN_W = FRAC_W + 1;
  localparam int unsigned EXT_W = MAN_W + 3;
  localparam int unsigned SUM_W = EXT_W + 1;
  localparam int unsigned E_W   = EXP_W + 2;
  localparam int unsigned LZ_W  = $clog2(EXT_W + 1);

  localparam logic [EXP_W-1:0]        EXP_MAX = '1;
  localparam logic signed [E_W-1:0]   EXP_TOP = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0]   EXP_ONE = E_W'(1);
  localparam logic [W-1:0]            QNAN    = {1'b0, EXP_MAX, 1'b1, (FRAC_W-1)'(0)};

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]              a_q, a_d, b_q, b_d;
  logic                      sa_q, sa_d, sb_q, sb_d;
  logic [EXP_W-1:0]          ea_q, ea_d, eb_q, eb_d;
  logic [MAN_W-1:0]          ma_q, ma_d, mb_q, mb_d;
  logic                      spec_q, spec_d;
  logic [W-1:0]              spec_val_q, spec_val_d;
  logic [EXT_W-1:0]          mb_al_q, mb_al_d;
  logic [SUM_W-1:0]          sum_q, sum_d;
  logic [EXT_W-1:0]          nman_q, nman_d;
  logic signed [E_W-1:0]     exp_q, exp_d;
  logic                      sign_q, sign_d;
  logic                      zero_q, zero_d;
  logic [W-1:0]              result_q, result_d;
  logic                      done_q, done_d;

  // Leading-zero count over the 27-bit extended mantissa; all-zero input returns EXT_W.
  function automatic logic [LZ_W-1:0] lzc(input logic [EXT_W-1:0] x);
    logic [LZ_W-1:0] n;
    n = LZ_W'(EXT_W);
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (x[i]) n = LZ_W'(int'(EXT_W) - 1 - i);
    end
    return n;
  endfunction

  // State register plus all datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      mb_al_q    <= '0;
      sum_q      <= '0;
      nman_q     <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      mb_al_q    <= mb_al_d;
      sum_q      <= sum_d;
      nman_q     <= nman_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      zero_q     <= zero_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  // Next state and operand capture; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_UNPACK;
          a_d     = dataa;
          b_d     = {datab[W-1] ^ sub, datab[W-2:0]};
          done_d  = 1'b0;
        end
      end
      S_UNPACK: state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ADD;
      S_ADD:    state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic             a_nan, b_nan, a_inf, b_inf, swap;
  logic [W-2:0]     a_mag, b_mag, big_mag, small_mag;

  // UNPACK: classify, flush exp==0 to zero, order so |A| >= |B|
  always_comb begin
    a_exp     = a_q[W-2:FRAC_W];
    b_exp     = b_q[W-2:FRAC_W];
    a_frac    = a_q[FRAC_W-1:0];
    b_frac    = b_q[FRAC_W-1:0];
    a_nan     = (a_exp == EXP_MAX) && (a_frac != '0);
    b_nan     = (b_exp == EXP_MAX) && (b_frac != '0);
    a_inf     = (a_exp == EXP_MAX) && (a_frac == '0);
    b_inf     = (b_exp == EXP_MAX) && (b_frac == '0);
    a_mag     = (a_exp == '0) ? '0 : a_q[W-2:0];
    b_mag     = (b_exp == '0) ? '0 : b_q[W-2:0];
    swap      = b_mag > a_mag;
    big_mag   = swap ? b_mag : a_mag;
    small_mag = swap ? a_mag : b_mag;

    sa_d       = sa_q;
    sb_d       = sb_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    if (state_q == S_UNPACK) begin
      sa_d       = swap ? b_q[W-1] : a_q[W-1];
      sb_d       = swap ? a_q[W-1] : b_q[W-1];
      ea_d       = big_mag[W-2:FRAC_W];
      eb_d       = small_mag[W-2:FRAC_W];
      ma_d       = {(big_mag[W-2:FRAC_W] != '0), big_mag[FRAC_W-1:0]};
      mb_d       = {(small_mag[W-2:FRAC_W] != '0), small_mag[FRAC_W-1:0]};
      spec_d     = 1'b1;
      spec_val_d = '0;
      if (a_nan || b_nan)                         spec_val_d = QNAN;
      else if (a_inf && b_inf && (a_q[W-1] != b_q[W-1])) spec_val_d = QNAN;
      else if (a_inf)                             spec_val_d = a_q;
      else if (b_inf)                             spec_val_d = b_q;
      else                                        spec_d     = 1'b0;
    end
  end

  logic [EXP_W-1:0] shamt;
  logic [EXT_W-1:0] b_ext, lost_mask;
  logic             lost_any;

  // ALIGN: shift B right into mantissa+G/R/S, folding lost bits into sticky
  always_comb begin
    shamt     = ea_q - eb_q;
    b_ext     = {mb_q, 3'b000};
    lost_mask = '0;
    lost_any  = 1'b0;
    mb_al_d   = mb_al_q;
    if (state_q == S_ALIGN) begin
      if (int'(shamt) >= int'(EXT_W)) begin
        mb_al_d = {(EXT_W-1)'(0), (mb_q != '0)};
      end else begin
        lost_mask = (EXT_W'(1) << shamt) - EXT_W'(1);
        lost_any  = (b_ext & lost_mask) != '0;
        mb_al_d   = (b_ext >> shamt) | EXT_W'(lost_any);
      end
    end
  end

  // ADD: magnitude add or subtract; swap guarantees a non-negative difference
  always_comb begin
    sum_d = sum_q;
    if (state_q == S_ADD) begin
      if (sa_q == sb_q) sum_d = {1'b0, ma_q, 3'b000} + {1'b0, mb_al_q};
      else              sum_d = {1'b0, ma_q, 3'b000} - {1'b0, mb_al_q};
    end
  end

  logic [LZ_W-1:0]       lz;
  logic signed [E_W-1:0] e_a, lz_e;

  // NORM: carry-out shifts right keeping sticky, otherwise shift out leading zeros
  always_comb begin
    lz     = lzc(sum_q[EXT_W-1:0]);
    e_a    = E_W'(ea_q);
    lz_e   = E_W'(lz);
    nman_d = nman_q;
    exp_d  = exp_q;
    sign_d = sign_q;
    zero_d = zero_q;
    if (state_q == S_NORM) begin
      sign_d = sa_q;
      zero_d = 1'b0;
      if (sum_q == '0) begin
        // Only equal-signed zeros keep their sign; true cancellation gives +0
        zero_d = 1'b1;
        sign_d = sa_q & sb_q;
        nman_d = '0;
        exp_d  = '0;
      end else if (sum_q[SUM_W-1]) begin
        nman_d = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
        exp_d  = e_a + EXP_ONE;
      end else begin
        nman_d = sum_q[EXT_W-1:0] << lz;
        exp_d  = e_a - lz_e;
      end
    end
  end

  logic [MAN_W-1:0]      m_keep;
  logic                  rnd_up;
  logic [MAN_W:0]        m_r;
  logic [FRAC_W-1:0]     frac_fin;
  logic signed [E_W-1:0] e_r;

  // ROUND: nearest-even on G/R/S, then resolve specials, overflow and underflow
  always_comb begin
    m_keep   = nman_q[EXT_W-1:3];
    rnd_up   = nman_q[2] & (nman_q[1] | nman_q[0] | m_keep[0]);
    m_r      = {1'b0, m_keep} + (MAN_W+1)'(rnd_up);
    frac_fin = m_r[MAN_W] ? m_r[MAN_W-1:1] : m_r[FRAC_W-1:0];
    e_r      = m_r[MAN_W] ? exp_q + EXP_ONE : exp_q;
    result_d = result_q;
    if (state_q == S_ROUND) begin
      if (spec_q)              result_d = spec_val_q;
      else if (zero_q)         result_d = {sign_q, (W-1)'(0)};
      else if (e_r >= EXP_TOP) result_d = {sign_q, EXP_MAX, FRAC_W'(0)};
      else if (e_r < EXP_ONE)  result_d = {sign_q, (W-1)'(0)};
      else                     result_d = {sign_q, e_r[EXP_W-1:0], frac_fin};
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fpadd.sv
// Scoreboard bench for fpadd: expected sums queued at start, popped when done rises.
module tb_fpadd;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  logic [31:0] sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  fpadd dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sub    (sub),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // One operation; poke=1 raises start with junk operands while the FSM is busy
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] want, input logic poke);
    int          cyc;
    logic [31:0] exp_v;
    @(negedge clk);
    dataa = a;
    datab = b;
    sub   = s;
    start = 1'b1;
    sb_q.push_back(want);
    @(posedge clk);
    #1;
    start = 1'b0;
    dataa = $urandom;
    datab = $urandom;
    sub   = 1'($urandom_range(0, 1));
    check({tag, " done_clr"}, 32'(done), 32'h0);
    cyc = 0;
    while (!done && cyc < 20) begin
      start = (poke && cyc == 1);
      if (start) begin
        dataa = 32'h7F800000;
        datab = 32'h3F800000;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'd5);
    exp_v = sb_q.pop_front();
    check({tag, " result"}, result, exp_v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    dataa = '0;
    datab = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset done", 32'(done), 32'h0);
    check("reset result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op("1.5+1.5", 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 1'b0);
    held = result;
    repeat (3) @(posedge clk);
    #1;
    check("hold done", 32'(done), 32'h1);
    check("hold result", result, held);

    run_op("-2.25+3", 32'hC0100000, 32'h40400000, 1'b0, 32'h3F400000, 1'b0);
    run_op("-2.25-3", 32'hC0100000, 32'h40400000, 1'b1, 32'hC0A80000, 1'b0);
    run_op("tie even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0);
    run_op("tie odd", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0);
    run_op("cancel", 32'h3FC00000, 32'hBFC00000, 1'b0, 32'h00000000, 1'b0);
    run_op("neg zeros", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0);
    run_op("ovf inf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0);
    run_op("inf-inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0);
    run_op("nan in", 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0);
    run_op("denorm flush", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0);
    run_op("self sub", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0);
    run_op("2+1", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0);
    run_op("one inf", 32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0);
    run_op("sub inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0);
    run_op("underflow", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0);
    run_op("far sticky", 32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 1'b0);
    run_op("busy start", 32'h3FC00000, 32'h3F800000, 1'b0, 32'h40200000, 1'b1);

    // Nothing must restart after the ignored mid-op start
    held = result;
    repeat (7) @(posedge clk);
    #1;
    check("no restart done", 32'(done), 32'h1);
    check("no restart result", result, held);

    // Asynchronous reset two cycles into an operation
    @(negedge clk);
    dataa = 32'h3FC00000;
    datab = 32'h3FC00000;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst mid done", 32'(done), 32'h0);
    check("rst mid result", result, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post rst done", 32'(done), 32'h0);
    check("post rst result", result, 32'h0);

    run_op("after rst", 32'hC0100000, 32'h40400000, 1'b0, 32'h3F400000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
